// File: rtl/fc_pkg.sv
// Shared constants and FSM state encoding for the fully-connected layer sequencer.
package fc_pkg;
    localparam int AW        = 12;  // source/destination buffer address width
    localparam int WAW       = 16;  // weight address width
    localparam int DRAIN_CYC = 3;   // cycles to flush the read/MAC/write pipeline

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
endpackage

// File: rtl/fc_exec_seq_if.sv
// Bus between the sequencer and the host/buffers. Names are seen from the
// sequencer: i_* flow into it, o_* flow out of it.
interface fc_exec_seq_if;
    import fc_pkg::*;

    logic           i_start;
    logic [AW-1:0]  i_id;
    logic [AW-1:0]  i_od;
    logic           o_busy;
    logic           o_done;
    logic           o_exec;
    logic [AW-1:0]  o_ia;
    real            i_d;
    logic [WAW-1:0] o_wa;
    real            i_wd;
    logic           o_outr;
    logic [AW-1:0]  o_oa;
    real            o_x;

    modport slave (
        input  i_start, i_id, i_od, i_d, i_wd,
        output o_busy, o_done, o_exec, o_ia, o_wa, o_outr, o_oa, o_x
    );

    modport master (
        output i_start, i_id, i_od, i_d, i_wd,
        input  o_busy, o_done, o_exec, o_ia, o_wa, o_outr, o_oa, o_x
    );
endinterface

// File: rtl/fc_mac.sv
// Real-valued multiply-accumulate; the first product of each output reloads
// the sum so the next output can start while the previous one is written out.
module fc_mac (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_v,
    input  logic i_first,
    input  real  i_d,
    input  real  i_wd,
    output real  o_acc
);
    real r_acc;

    // Accumulate one product per valid read-data cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_acc <= 0.0;
        else if (i_v)
            r_acc <= (i_first ? 0.0 : r_acc) + i_d * i_wd;
    end

    assign o_acc = r_acc;
endmodule

// File: rtl/fc_exec_seq.sv
// Sequencer for one fully-connected layer pass: streams source/weight reads,
// accumulates each dot product and writes it to the destination buffer.
import fc_pkg::*;

module fc_exec_seq (
    input  logic         i_clk,
    input  logic         i_reset,
    fc_exec_seq_if.slave bus
);
    state_t         r_state;
    logic [AW-1:0]  r_idm1;
    logic [AW-1:0]  r_odm1;
    logic [AW-1:0]  r_i;
    logic [AW-1:0]  r_o;
    logic [WAW-1:0] r_wa;
    logic [1:0]     r_dcnt;
    logic           r_exec;
    logic           r_busy;
    logic           r_done;
    logic           r_v1;
    logic           r_first1;
    logic           r_outr;
    logic [AW-1:0]  r_oa;
    real            w_acc;

    // r_i/r_o always mirror the read currently on ia, so these flags describe it.
    wire w_last_i = (r_i == r_idm1);
    wire w_last   = w_last_i && (r_o == r_odm1);

    // Control FSM and read-address generation; wa is a running counter equal to o*id+i.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_idm1  <= '0;
            r_odm1  <= '0;
            r_i     <= '0;
            r_o     <= '0;
            r_wa    <= '0;
            r_dcnt  <= '0;
            r_exec  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // busy is still high in the done cycle, which blocks a start there
                    r_busy <= 1'b0;
                    if (bus.i_start && !r_busy) begin
                        r_busy <= 1'b1;
                        r_idm1 <= bus.i_id - 1'b1;
                        r_odm1 <= bus.i_od - 1'b1;
                        r_i    <= '0;
                        r_o    <= '0;
                        r_wa   <= '0;
                        if (bus.i_id != '0 && bus.i_od != '0) begin
                            r_exec  <= 1'b1;
                            r_state <= RUN;
                        end else begin
                            r_state <= FIN;
                        end
                    end
                end
                RUN: begin
                    if (w_last) begin
                        r_exec  <= 1'b0;
                        r_dcnt  <= '0;
                        r_state <= DRAIN;
                    end else begin
                        r_wa <= r_wa + 1'b1;
                        if (w_last_i) begin
                            r_i <= '0;
                            r_o <= r_o + 1'b1;
                        end else begin
                            r_i <= r_i + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (r_dcnt == 2'(DRAIN_CYC - 1))
                        r_state <= FIN;
                    else
                        r_dcnt <= r_dcnt + 1'b1;
                end
                FIN: begin
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Delay read qualifiers by the buffer latency so they line up with d/wd.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_v1     <= 1'b0;
            r_first1 <= 1'b0;
            r_outr   <= 1'b0;
            r_oa     <= '0;
        end else begin
            r_v1     <= r_exec;
            r_first1 <= r_exec && (r_i == '0);
            r_outr   <= r_exec && w_last_i;
            if (r_exec && w_last_i)
                r_oa <= r_o;
        end
    end

    fc_mac u_mac (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_v     (r_v1),
        .i_first (r_first1),
        .i_d     (bus.i_d),
        .i_wd    (bus.i_wd),
        .o_acc   (w_acc)
    );

    assign bus.o_busy = r_busy;
    assign bus.o_done = r_done;
    assign bus.o_exec = r_exec;
    assign bus.o_ia   = r_i;
    assign bus.o_wa   = r_wa;
    assign bus.o_outr = r_outr;
    assign bus.o_oa   = r_oa;
    // destination buffer writes x one cycle after outr, when the sum is complete
    assign bus.o_x    = w_acc;
endmodule

// File: tb/tb_fc_exec_seq.sv
// Bench for fc_exec_seq: buffer models with one-cycle read latency, a queue of
// expected destination writes, and a table of pass shapes plus corner sequences.
module tb_fc_exec_seq;
    import fc_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fc_exec_seq_if bus ();

    fc_exec_seq dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    typedef struct {
        int id;
        int od;
        int mode;      // 0: fixed small pattern, 1: all 2.0, 2: random
        int done_cyc;  // expected done cycle counted from the start edge
    } vec_t;

    typedef struct {
        int  oa;
        real x;
    } wr_t;

    real src_mem [4096];
    real w_mem   [65536];
    int  wcnt    [4096];
    wr_t exp_q [$];

    int  n_cmp = 0;
    int  n_fail = 0;
    int  cyc;
    bit  mon_en;
    int  cur_id;
    int  m_i, m_wa, wa_max;
    int  n_exec, n_outr, done_cyc;
    bit  pend;
    int  pend_oa;
    real pend_x;
    real nd = 0.0, nwd = 0.0;

    task automatic chk_int(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_real(input string nm, input real act, input real exp);
        real diff, tol;
        diff = (act > exp) ? act - exp : exp - act;
        tol  = 1e-9 * ((exp < 0.0) ? -exp : exp) + 1e-12;
        n_cmp++;
        if (diff > tol) begin
            n_fail++;
            $display("FAIL %s: got %g expected %g (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Destination-buffer view of the write port: latch oa on outr, take x next cycle.
    task automatic monitor();
        wr_t e;
        if (pend) begin
            chk_real("x", bus.o_x, pend_x);
            wcnt[pend_oa]++;
            pend = 1'b0;
        end
        if (bus.o_exec) begin
            chk_int("ia", bus.o_ia, m_i);
            chk_int("wa", bus.o_wa, m_wa);
            if (int'(bus.o_wa) > wa_max) wa_max = int'(bus.o_wa);
            n_exec++;
            m_wa = (m_wa + 1) % 65536;
            m_i  = (m_i == cur_id - 1) ? 0 : m_i + 1;
        end
        if (bus.o_outr) begin
            n_outr++;
            if (exp_q.size() == 0) begin
                chk_int("outr_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk_int("oa", bus.o_oa, e.oa);
                chk_int("outr_cycle", cyc, e.oa * cur_id + cur_id + 1);
                pend    = 1'b1;
                pend_oa = e.oa;
                pend_x  = e.x;
            end
        end
        if (bus.o_done && done_cyc < 0) done_cyc = cyc;
    endtask

    // One clock: return read data for last cycle's reads, then observe at negedge.
    task automatic tick();
        @(posedge clk);
        #1;
        bus.i_d  = nd;
        bus.i_wd = nwd;
        @(negedge clk);
        cyc++;
        if (mon_en) monitor();
        if (bus.o_exec) begin
            nd  = src_mem[bus.o_ia];
            nwd = w_mem[bus.o_wa];
        end
    endtask

    task automatic fill(input int mode, input int id, input int od);
        if (mode == 0) begin
            src_mem[0] = 1.0; src_mem[1] = 2.0; src_mem[2] = 3.0;
            w_mem[0] = 1.0; w_mem[1] = 1.0; w_mem[2] = 1.0;
            w_mem[3] = 0.5; w_mem[4] = 0.0; w_mem[5] = 2.0;
        end else begin
            for (int k = 0; k < id; k++)
                src_mem[k] = (mode == 1) ? 2.0 : real'($urandom_range(2000000)) / 1.0e6 - 1.0;
            for (int k = 0; k < id * od; k++)
                w_mem[k] = (mode == 1) ? 2.0 : real'($urandom_range(2000000)) / 1.0e6 - 1.0;
        end
    endtask

    task automatic clear_mon(input int id);
        exp_q.delete();
        cur_id = id; m_i = 0; m_wa = 0; wa_max = 0;
        pend = 1'b0; n_exec = 0; n_outr = 0; done_cyc = -1;
        for (int k = 0; k < 4096; k++) wcnt[k] = 0;
    endtask

    task automatic run_pass(input string nm, input int id, input int od,
                            input int exp_done, input int restart_cyc);
        real s;
        int  bad;
        clear_mon(id);
        if (id != 0) begin
            for (int o = 0; o < od; o++) begin
                s = 0.0;
                for (int k = 0; k < id; k++) s = s + src_mem[k] * w_mem[o * id + k];
                exp_q.push_back('{oa: o, x: s});
            end
        end
        cyc = 0;
        bus.i_id    = 12'(id);
        bus.i_od    = 12'(od);
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        chk_int({nm, ".busy_rise"}, bus.o_busy, 1);
        while (done_cyc < 0 && cyc < exp_done + 20) begin
            bus.i_start = (cyc == restart_cyc);
            tick();
        end
        bus.i_start = 1'b0;
        chk_int({nm, ".done_cycle"}, done_cyc, exp_done);
        tick();
        chk_int({nm, ".done_pulse"}, bus.o_done, 0);
        chk_int({nm, ".busy_fall"}, bus.o_busy, 0);
        chk_int({nm, ".exec_count"}, n_exec, id * od);
        chk_int({nm, ".outr_count"}, n_outr, (id == 0) ? 0 : od);
        chk_int({nm, ".exp_left"}, exp_q.size(), 0);
        bad = 0;
        if (id != 0)
            for (int o = 0; o < od; o++) if (wcnt[o] != 1) bad++;
        chk_int({nm, ".dst_once"}, bad, 0);
    endtask

    task automatic chk_all_zero(input string nm);
        chk_int({nm, ".busy"}, bus.o_busy, 0);
        chk_int({nm, ".done"}, bus.o_done, 0);
        chk_int({nm, ".exec"}, bus.o_exec, 0);
        chk_int({nm, ".ia"}, bus.o_ia, 0);
        chk_int({nm, ".wa"}, bus.o_wa, 0);
        chk_int({nm, ".outr"}, bus.o_outr, 0);
        chk_int({nm, ".oa"}, bus.o_oa, 0);
        chk_real({nm, ".x"}, bus.o_x, 0.0);
    endtask

    vec_t vecs [5];

    initial begin
        vecs[0] = '{id: 3, od: 2, mode: 0, done_cyc: 11};
        vecs[1] = '{id: 1, od: 4, mode: 1, done_cyc: 9};
        vecs[2] = '{id: 0, od: 5, mode: 1, done_cyc: 2};
        vecs[3] = '{id: 6, od: 0, mode: 1, done_cyc: 2};
        vecs[4] = '{id: 2, od: 3, mode: 2, done_cyc: 11};

        bus.i_start = 1'b0;
        bus.i_id    = '0;
        bus.i_od    = '0;
        bus.i_d     = 0.0;
        bus.i_wd    = 0.0;
        mon_en      = 1'b0;
        cyc         = 0;
        reset       = 1'b1;
        tick();
        tick();
        chk_all_zero("reset");
        reset  = 1'b0;
        mon_en = 1'b1;

        for (int v = 0; v < 5; v++) begin
            fill(vecs[v].mode, vecs[v].id, vecs[v].od);
            run_pass($sformatf("vec%0d", v), vecs[v].id, vecs[v].od, vecs[v].done_cyc, -1);
        end

        // A second start during RUN must not disturb the pass.
        fill(0, 3, 2);
        run_pass("restart", 3, 2, 11, 3);

        // Abort on the second read, then a fresh pass must not inherit the partial sum.
        mon_en = 1'b0;
        cyc = 0;
        bus.i_id    = 12'd3;
        bus.i_od    = 12'd2;
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        tick();
        chk_int("abort.exec2", bus.o_exec, 1);
        reset = 1'b1;
        tick();
        chk_all_zero("abort");
        reset  = 1'b0;
        mon_en = 1'b1;
        run_pass("after_abort", 2, 1, 7, -1);

        // Full-size pass with random data.
        fill(2, 4095, 16);
        run_pass("full", 4095, 16, 65525, -1);
        chk_int("full.wa_max", wa_max, 65519);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
